// File: rtl/chu_sprite_pkg.sv
// rtl/chu_sprite_pkg.sv - shared register map, per-sprite register struct and collision width
package chu_sprite_pkg;

  localparam logic [1:0] REG_EN      = 2'd0;
  localparam logic [1:0] REG_X0      = 2'd1;
  localparam logic [1:0] REG_Y0      = 2'd2;
  localparam logic [1:0] GREG_BYPASS = 2'd0;
  localparam logic [1:0] GREG_COLL   = 2'd1;

  localparam int COLL_W = 4;

  typedef struct packed {
    logic        en;
    logic [10:0] x0;
    logic [10:0] y0;
  } sprite_reg_t;

endpackage

// File: rtl/chu_sprite_src.sv
// rtl/chu_sprite_src.sv - one sprite: pixel RAM, hit detect, 1-clock registered read
module chu_sprite_src
  import chu_sprite_pkg::*;
#(
  parameter int CD          = 12,
  parameter int ADDR_WIDTH  = 10,
  parameter int SPRITE_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [CD-1:0]         wdata_i,
  input  logic [10:0]           x_i,
  input  logic [10:0]           y_i,
  input  sprite_reg_t           act_i,
  output logic                  hit_o,
  output logic [CD-1:0]         pix_o
);

  logic [CD-1:0]         ram_q [2**ADDR_WIDTH];
  logic [CD-1:0]         pix_q;
  logic                  hit_q;
  logic                  hit_d;
  logic [11:0]           x_end;
  logic [11:0]           y_end;
  logic [10:0]           dx;
  logic [10:0]           dy;
  logic [ADDR_WIDTH-1:0] raddr;

  // 12-bit window ends so a sprite near column 2047 does not wrap to zero
  assign x_end = {1'b0, act_i.x0} + 12'(SPRITE_SIZE);
  assign y_end = {1'b0, act_i.y0} + 12'(SPRITE_SIZE);
  assign hit_d = act_i.en
              && (x_i >= act_i.x0) && ({1'b0, x_i} < x_end)
              && (y_i >= act_i.y0) && ({1'b0, y_i} < y_end);

  assign dx    = x_i - act_i.x0;
  assign dy    = y_i - act_i.y0;
  assign raddr = ADDR_WIDTH'(32'(dy) * 32'(SPRITE_SIZE) + 32'(dx));

  always_ff @(posedge clk) begin
    if (we_i) ram_q[waddr_i] <= wdata_i;
    pix_q <= ram_q[raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hit_q <= 1'b0;
    else          hit_q <= hit_d;
  end

  assign hit_o = hit_q;
  assign pix_o = pix_q;

endmodule

// File: rtl/chu_sprite_bank_core.sv
// rtl/chu_sprite_bank_core.sv - N-sprite overlay with shadowed position registers and fixed priority
// Optional collision status: define SPRITE_COLLISION_EN.
module chu_sprite_bank_core
  import chu_sprite_pkg::*;
#(
  parameter int CD          = 12,
  parameter int ADDR_WIDTH  = 10,
  parameter int N_SPRITE    = 4,
  parameter int KEY_COLOR   = 0,
  parameter int SPRITE_SIZE = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  sprite_reg_t         sh_q  [N_SPRITE];
  sprite_reg_t         sh_d  [N_SPRITE];
  sprite_reg_t         act_q [N_SPRITE];
  sprite_reg_t         act_d [N_SPRITE];
  logic                bypass_q;
  logic                bypass_d;
  logic [CD-1:0]       si_d1_q;
  logic [CD-1:0]       so_rgb_q;
  logic [CD-1:0]       so_rgb_d;
  logic [N_SPRITE-1:0] hit_s;
  logic [CD-1:0]       pix_s [N_SPRITE];
  logic [N_SPRITE-1:0] opaque;
  logic [COLL_W-1:0]   coll_status;
  logic                frame_start;
  logic                spr_wr;
  logic                glb_wr;
  logic                unused_bits;

  assign frame_start = (x == 11'd0) && (y == 11'd0);
  assign spr_wr      = cs && write && addr[13] && !addr[4];
  assign glb_wr      = cs && write && addr[13] && addr[4];
  assign unused_bits = ^{read, addr[12], wr_data[31:CD]};

  // Shadow takes this cycle's write, so a write at frame start lands in active at once
  always_comb begin
    sh_d     = sh_q;
    bypass_d = bypass_q;
    for (int i = 0; i < N_SPRITE; i++) begin
      if (spr_wr && addr[3:2] == 2'(i)) begin
        case (addr[1:0])
          REG_EN:  sh_d[i].en = wr_data[0];
          REG_X0:  sh_d[i].x0 = wr_data[10:0];
          REG_Y0:  sh_d[i].y0 = wr_data[10:0];
          default: ;
        endcase
      end
    end
    if (glb_wr && addr[1:0] == GREG_BYPASS) bypass_d = wr_data[0];
    act_d = act_q;
    if (frame_start) act_d = sh_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SPRITE; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
      bypass_q <= 1'b0;
      si_d1_q  <= '0;
      so_rgb_q <= '0;
    end else begin
      sh_q     <= sh_d;
      act_q    <= act_d;
      bypass_q <= bypass_d;
      si_d1_q  <= si_rgb;
      so_rgb_q <= so_rgb_d;
    end
  end

  for (genvar g = 0; g < N_SPRITE; g++) begin : g_src
    chu_sprite_src #(
      .CD          (CD),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SPRITE_SIZE (SPRITE_SIZE)
    ) u_src (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (cs && write && !addr[13] && addr[ADDR_WIDTH+1:ADDR_WIDTH] == 2'(g)),
      .waddr_i (addr[ADDR_WIDTH-1:0]),
      .wdata_i (wr_data[CD-1:0]),
      .x_i     (x),
      .y_i     (y),
      .act_i   (act_q[g]),
      .hit_o   (hit_s[g]),
      .pix_o   (pix_s[g])
    );
  end

  // Descending scan so the lowest-index opaque sprite is the last to overwrite
  always_comb begin
    so_rgb_d = si_d1_q;
    opaque   = '0;
    for (int i = N_SPRITE - 1; i >= 0; i--) begin
      opaque[i] = hit_s[i] && (pix_s[i] != CD'(KEY_COLOR));
      if (opaque[i]) so_rgb_d = pix_s[i];
    end
    if (bypass_q) so_rgb_d = si_d1_q;
  end

`ifdef SPRITE_COLLISION_EN
  logic [COLL_W-1:0] coll_q;
  logic [COLL_W-1:0] coll_d;
  logic [COLL_W-1:0] coll_set;
  logic [COLL_W-1:0] coll_clr;
  logic [COLL_W-1:0] opaque_w;

  assign opaque_w = COLL_W'(opaque);
  assign coll_clr = (glb_wr && addr[1:0] == GREG_COLL) ? wr_data[COLL_W-1:0] : '0;

  always_comb begin
    coll_set = '0;
    for (int i = 0; i < COLL_W; i++) begin
      coll_set[i] = opaque_w[i] && |(opaque_w & ~(COLL_W'(1) << i));
    end
    coll_d = (coll_q & ~coll_clr) | coll_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) coll_q <= '0;
    else          coll_q <= coll_d;
  end

  assign coll_status = coll_q;
`else
  assign coll_status = '0;
`endif

  always_comb begin
    rd_data = '0;
    if (addr[13]) begin
      if (!addr[4]) begin
        for (int i = 0; i < N_SPRITE; i++) begin
          if (addr[3:2] == 2'(i)) begin
            case (addr[1:0])
              REG_EN:  rd_data[0]    = sh_q[i].en;
              REG_X0:  rd_data[10:0] = sh_q[i].x0;
              REG_Y0:  rd_data[10:0] = sh_q[i].y0;
              default: ;
            endcase
          end
        end
      end else begin
        case (addr[1:0])
          GREG_BYPASS: rd_data[0]          = bypass_q;
          GREG_COLL:   rd_data[COLL_W-1:0] = coll_status;
          default:     ;
        endcase
      end
    end
  end

  assign so_rgb = so_rgb_q;

endmodule

// File: tb/tb_chu_sprite_bank_core.sv
// tb/tb_chu_sprite_bank_core.sv - scoreboard bench for chu_sprite_bank_core
module tb_chu_sprite_bank_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        cs, write, read;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [11:0] si_rgb, so_rgb;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q [$];

  int m_ram [2][1024];
  int m_en [4], m_x0 [4], m_y0 [4];
  int a_en [4], a_x0 [4], a_y0 [4];
  int m_bypass, m_coll;

`ifdef SPRITE_COLLISION_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  chu_sprite_bank_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .read    (read),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0; m_x0[i] = 0; m_y0[i] = 0;
      a_en[i] = 0; a_x0[i] = 0; a_y0[i] = 0;
    end
    m_bypass = 0;
    m_coll   = 0;
  endtask

  // One pixel clock: check the output due from two cycles ago, then drive and predict
  task automatic cyc(input int xi, input int yi, input bit wr, input logic [13:0] a,
                     input logic [31:0] d);
    int       si, e, p, idx;
    bit       found;
    bit [3:0] om;
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) chk("so_rgb", {20'd0, so_rgb}, {20'd0, exp_q.pop_front()});
    si      = $urandom_range(0, 4095);
    x       = 11'(xi);
    y       = 11'(yi);
    si_rgb  = 12'(si);
    cs      = wr;
    write   = wr;
    addr    = a;
    wr_data = d;
    e = si; found = 0; om = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_en[i] != 0 && xi >= a_x0[i] && xi < a_x0[i] + 32 &&
          yi >= a_y0[i] && yi < a_y0[i] + 32) begin
        p = (i < 2) ? m_ram[i][(yi - a_y0[i]) * 32 + (xi - a_x0[i])] : 0;
        if (p != 0) begin
          om[i] = 1'b1;
          if (!found) begin e = p; found = 1; end
        end
      end
    end
    if ($countones(om) >= 2) m_coll = m_coll | int'(om);
    if (m_bypass != 0) e = si;
    exp_q.push_back(12'(e));
    if (wr) begin
      if (!a[13]) begin
        if (a[11:10] < 2) m_ram[a[11:10]][a[9:0]] = int'(d[11:0]);
      end else if (!a[4]) begin
        idx = int'(a[3:2]);
        case (a[1:0])
          2'd0: m_en[idx] = int'(d[0]);
          2'd1: m_x0[idx] = int'(d[10:0]);
          2'd2: m_y0[idx] = int'(d[10:0]);
          default: ;
        endcase
      end else begin
        case (a[1:0])
          2'd0: m_bypass = int'(d[0]);
          2'd1: m_coll = m_coll & ~int'(d[3:0]);
          default: ;
        endcase
      end
    end
    if (xi == 0 && yi == 0) begin
      for (int i = 0; i < 4; i++) begin
        a_en[i] = m_en[i]; a_x0[i] = m_x0[i]; a_y0[i] = m_y0[i];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2000, 2000, 0, 14'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [13:0] a, input logic [31:0] d);
    cyc(2000, 2000, 1, a, d);
    idle(1);
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] e);
    cs    = 1'b1;
    write = 1'b0;
    addr  = a;
    #1;
    chk(tag, rd_data, e);
  endtask

  initial begin
    reset_n = 1'b0;
    x = 11'd2000; y = 11'd2000; cs = 0; write = 0; read = 0;
    addr = 14'h2000; wr_data = 0; si_rgb = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_so", {20'd0, so_rgb}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int p = 0; p < 1024; p++)
      cyc(2000, 2000, 1, 14'(p), (p == 5) ? 32'h0 : (p < 512) ? 32'hF00 : 32'h0F0);
    for (int p = 0; p < 1024; p++)
      cyc(2000, 2000, 1, 14'(1024 + p), (p == 40) ? 32'h0 : 32'h00F);
    idle(1);

    wr_reg(14'h2000, 32'd1);
    wr_reg(14'h2001, 32'd100);
    wr_reg(14'h2002, 32'd50);
    rd("rd_x0", 14'h2001, 32'd100);
    rd("rd_y0", 14'h2002, 32'd50);
    rd("rd_rsv", 14'h2003, 32'd0);
    rd("rd_ram", 14'h0005, 32'd0);
    // Not yet at frame start: sprite stays invisible
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(0, 0, 0, 14'd0, 32'd0);
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(101, 50, 0, 14'd0, 32'd0);
    cyc(105, 50, 0, 14'd0, 32'd0);
    cyc(132, 50, 0, 14'd0, 32'd0);
    cyc(131, 81, 0, 14'd0, 32'd0);
    cyc(99, 50, 0, 14'd0, 32'd0);
    cyc(100, 82, 0, 14'd0, 32'd0);

    cyc(120, 60, 1, 14'h2001, 32'd200);
    cyc(121, 60, 0, 14'd0, 32'd0);
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(200, 50, 0, 14'd0, 32'd0);
    cyc(0, 0, 0, 14'd0, 32'd0);
    cyc(200, 50, 0, 14'd0, 32'd0);
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(0, 0, 1, 14'h2002, 32'd300);
    cyc(200, 300, 0, 14'd0, 32'd0);
    cyc(215, 320, 0, 14'd0, 32'd0);
    wr_reg(14'h2001, 32'd100);
    wr_reg(14'h2002, 32'd50);

    wr_reg(14'h2004, 32'd1);
    wr_reg(14'h2005, 32'd100);
    wr_reg(14'h2006, 32'd50);
    cyc(0, 0, 0, 14'd0, 32'd0);
    cyc(100, 66, 0, 14'd0, 32'd0);
    cyc(105, 50, 0, 14'd0, 32'd0);
    cyc(108, 51, 0, 14'd0, 32'd0);
    idle(3);
    rd("coll_set", 14'h2011, COLL_ON ? 32'h3 : 32'h0);
    wr_reg(14'h2011, 32'h1);
    rd("coll_w1c", 14'h2011, COLL_ON ? 32'h2 : 32'h0);
    chk("coll_model", 32'(m_coll), 32'h2);

    wr_reg(14'h2010, 32'd1);
    rd("rd_bypass", 14'h2010, 32'd1);
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(100, 66, 0, 14'd0, 32'd0);
    cyc(131, 81, 0, 14'd0, 32'd0);
    idle(1);
    wr_reg(14'h2010, 32'd0);
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(101, 50, 0, 14'd0, 32'd0);
    cyc(102, 50, 0, 14'd0, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_so", {20'd0, so_rgb}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    model_reset();
    rd("rst_en0", 14'h2000, 32'd0);
    rd("rst_coll", 14'h2011, 32'd0);
    cyc(0, 0, 0, 14'd0, 32'd0);
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(101, 50, 0, 14'd0, 32'd0);
    wr_reg(14'h2000, 32'd1);
    cyc(100, 50, 0, 14'd0, 32'd0);
    cyc(0, 0, 0, 14'd0, 32'd0);
    cyc(0, 0, 0, 14'd0, 32'd0);
    cyc(0, 0, 0, 14'd0, 32'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
